// File: rtl/shift_deserializer_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: word width, FSM states, shift helper.
// The PARITY state exists only when DESER_PARITY_EN is defined.
package shift_deserializer_pkg;

  localparam int WORD_W = 4;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1
`ifdef DESER_PARITY_EN
    ,
    PARITY  = 2'd2
`endif
  } state_t;

  // MSB-first words enter at bit 0 and shift left; LSB-first words enter at the top and shift right.
  function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] cur,
                                                 input logic              b,
                                                 input logic              lsb_first);
    return lsb_first ? {b, cur[WORD_W-1:1]} : {cur[WORD_W-2:0], b};
  endfunction

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial-bit input / parallel-word output bundle of the deserializer.
// PARITY_ERR is present only when DESER_PARITY_EN is defined.
interface shift_deserializer_if;
  import shift_deserializer_pkg::*;

  logic              bit_in;
  logic              bit_valid;
  logic              dir;
  logic              clear;
  logic [WORD_W-1:0] out;
  logic              out_valid;
  logic              busy;
  logic [CNT_W-1:0]  count;
`ifdef DESER_PARITY_EN
  logic              parity_err;
`endif

  modport master (
    output bit_in, bit_valid, dir, clear,
    input  out, out_valid, busy, count
`ifdef DESER_PARITY_EN
    ,
    input  parity_err
`endif
  );

  modport slave (
    input  bit_in, bit_valid, dir, clear,
    output out, out_valid, busy, count
`ifdef DESER_PARITY_EN
    ,
    output parity_err
`endif
  );

endinterface

// File: rtl/shift_deserializer.sv
// Collects 4 serial bits (MSB- or LSB-first) into a word; OUT/OUT_VALID one cycle after the last bit.
// No backpressure: bits are taken whenever BIT_VALID is high. Optional even parity via DESER_PARITY_EN.
module shift_deserializer
  import shift_deserializer_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  shift_deserializer_if.slave  s_if
);

  state_t            r_state;
  logic              r_dir;
  logic [WORD_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_count;
  logic [WORD_W-1:0] r_out;
  logic              r_out_valid;
  logic [WORD_W-1:0] w_first;
  logic [WORD_W-1:0] w_next;
  logic              w_last_data;
`ifdef DESER_PARITY_EN
  logic              r_parity_err;
`endif

  // The first bit uses the live DIR; later bits use the direction latched with it.
  assign w_first     = shift_in('0, s_if.bit_in, s_if.dir);
  assign w_next      = shift_in(r_shreg, s_if.bit_in, r_dir);
  assign w_last_data = (r_count == 3'(WORD_W - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_dir        <= 1'b0;
      r_shreg      <= '0;
      r_count      <= '0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
`ifdef DESER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_out_valid  <= 1'b0;
`ifdef DESER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (s_if.clear) begin
        r_state <= IDLE;
        r_count <= '0;
        r_shreg <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (s_if.bit_valid) begin
              r_dir   <= s_if.dir;
              r_shreg <= w_first;
              r_count <= 3'd1;
              r_state <= COLLECT;
            end
          end
          COLLECT: begin
            if (s_if.bit_valid) begin
              if (w_last_data) begin
`ifdef DESER_PARITY_EN
                r_shreg <= w_next;
                r_count <= 3'(WORD_W);
                r_state <= PARITY;
`else
                r_out       <= w_next;
                r_out_valid <= 1'b1;
                r_shreg     <= '0;
                r_count     <= '0;
                r_state     <= IDLE;
`endif
              end else begin
                r_shreg <= w_next;
                r_count <= r_count + 3'd1;
              end
            end
          end
`ifdef DESER_PARITY_EN
          PARITY: begin
            if (s_if.bit_valid) begin
              r_out        <= r_shreg;
              r_out_valid  <= 1'b1;
              r_parity_err <= (^r_shreg) ^ s_if.bit_in;
              r_shreg      <= '0;
              r_count      <= '0;
              r_state      <= IDLE;
            end
          end
`endif
          default: begin
            r_state <= IDLE;
            r_count <= '0;
          end
        endcase
      end
    end
  end

  assign s_if.out        = r_out;
  assign s_if.out_valid  = r_out_valid;
  assign s_if.busy       = (r_state != IDLE);
  assign s_if.count      = r_count;
`ifdef DESER_PARITY_EN
  assign s_if.parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer: directed word examples plus randomized traffic vs. a bit-queue model.
module tb_shift_deserializer;
  import shift_deserializer_pkg::*;

`ifdef DESER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_deserializer_if intf();

  shift_deserializer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .s_if    (intf.slave)
  );

  typedef struct {
    logic [3:0] word;
    logic       perr;
  } exp_t;

  int         tests = 0;
  int         fails = 0;
  exp_t       exp_q[$];
  bit         bits_q[$];
  bit         m_dir;
  int         m_count;
  logic [3:0] m_last;
  bit         m_ov;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: accepted bits are queued; a full queue is turned into a word by position arithmetic.
  task automatic model_step(input bit bv, input bit b, input bit d, input bit clr);
    logic [3:0] w;
    bit         p;
    if (!rst_n) return;
    m_ov = 0;
    if (clr) begin
      bits_q.delete();
    end else if (bv) begin
      if (bits_q.size() == 0) m_dir = d;
      bits_q.push_back(b);
      if (bits_q.size() == 4 + P) begin
        w = '0;
        p = 0;
        for (int i = 0; i < 4; i++) begin
          if (m_dir) w[i] = bits_q[i];
          else       w[3-i] = bits_q[i];
          p ^= bits_q[i];
        end
        if (P == 1) p ^= bits_q[4];
        exp_q.push_back('{word: w, perr: p});
        m_last = w;
        m_ov   = 1;
        bits_q.delete();
      end
    end
    m_count = bits_q.size();
  endtask

  task automatic step(input bit bv, input bit b, input bit d, input bit clr);
    intf.bit_valid = bv;
    intf.bit_in    = b;
    intf.dir       = d;
    intf.clear     = clr;
    @(posedge clk);
    model_step(bv, b, d, clr);
    #1;
    intf.bit_valid = 1'b0;
    intf.clear     = 1'b0;
  endtask

  task automatic model_reset();
    bits_q.delete();
    exp_q.delete();
    m_count = 0;
    m_last  = '0;
    m_ov    = 0;
    m_dir   = 0;
  endtask

  // Monitor: pops the scoreboard on each OUT_VALID and checks the per-cycle state outputs.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      check("out_valid", intf.out_valid, m_ov);
      if (intf.out_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h, expected no OUT_VALID", intf.out);
        end else begin
          e = exp_q.pop_front();
          check("out_word", intf.out, e.word);
`ifdef DESER_PARITY_EN
          check("parity_err", intf.parity_err, e.perr);
`endif
        end
      end
      check("out_hold", intf.out, m_last);
      check("count", intf.count, m_count);
      check("busy", intf.busy, m_count != 0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    intf.bit_in = 1'b0; intf.bit_valid = 1'b0; intf.dir = 1'b0; intf.clear = 1'b0;
    model_reset();
    #12;
    check("rst_out", intf.out, 4'b0000);
    check("rst_out_valid", intf.out_valid, 1'b0);
    check("rst_busy", intf.busy, 1'b0);
    check("rst_count", intf.count, 3'd0);
    #5 rst_n = 1'b1;

    // MSB first 1,0,1,1
    step(1,1,0,0); step(1,0,0,0); step(1,1,0,0); step(1,1,0,0);
    if (P == 1) step(1,1,0,0);
    check("msb_out", intf.out, 4'b1011);
    check("msb_ov", intf.out_valid, 1'b1);
    check("msb_count", intf.count, 3'd0);
    step(0,0,0,0);

    // LSB first 1,0,1,1 with DIR toggling after the first bit
    step(1,1,1,0); step(1,0,0,0); step(1,1,0,0); step(1,1,1,0);
    if (P == 1) step(1,1,0,0);
    check("lsb_out", intf.out, 4'b1101);
    step(0,0,1,0);

    // Gaps, then a back-to-back word starting in the OUT_VALID cycle
    step(1,0,0,0); step(1,1,0,0);
    step(0,0,1,0); step(0,1,1,0); step(0,0,1,0);
    step(1,1,1,0); step(1,0,1,0);
    if (P == 1) step(1,0,0,0);
    check("gap_out", intf.out, 4'b0110);
    check("gap_ov", intf.out_valid, 1'b1);
    step(1,1,0,0); step(1,1,0,0); step(1,1,0,0); step(1,1,0,0);
    if (P == 1) step(1,0,0,0);
    check("b2b_out", intf.out, 4'b1111);
    step(0,0,0,0);

    // Abort with simultaneous BIT_VALID
    step(1,1,0,0); step(1,0,0,0); step(1,1,0,1);
    check("abort_count", intf.count, 3'd0);
    check("abort_busy", intf.busy, 1'b0);
    check("abort_out", intf.out, 4'b1111);
    check("abort_ov", intf.out_valid, 1'b0);
    step(0,0,0,0);

    // Asynchronous reset between edges after 3 bits
    step(1,1,0,0); step(1,1,0,0); step(1,1,0,0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out", intf.out, 4'b0000);
    check("arst_ov", intf.out_valid, 1'b0);
    check("arst_busy", intf.busy, 1'b0);
    check("arst_count", intf.count, 3'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1,0,0,0); step(1,0,0,0); step(1,0,0,0); step(1,1,0,0);
    if (P == 1) step(1,1,0,0);
    check("arst_word", intf.out, 4'b0001);
    step(0,0,0,0);

`ifdef DESER_PARITY_EN
    step(1,1,0,0); step(1,0,0,0); step(1,1,0,0); step(1,1,0,0); step(1,1,0,0);
    check("par_ok_out", intf.out, 4'b1011);
    check("par_ok_err", intf.parity_err, 1'b0);
    step(1,1,0,0); step(1,0,0,0); step(1,1,0,0); step(1,1,0,0); step(1,0,0,0);
    check("par_bad_err", intf.parity_err, 1'b1);
    step(0,0,0,0);
`endif

    // Randomized traffic: gaps, DIR noise, occasional aborts
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);
    end
    repeat (3) step(0,0,0,0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 The block SHALL expose CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 The block SHALL expose RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 The block SHALL expose BIT_IN  input  1  serial data bit, i.e. the bit shifted out of the shift register's FLAG.
REQ-004 The block SHALL expose BIT_VALID  input  1  BIT_IN is accepted on this edge when high.
REQ-005 The block SHALL expose DIR  input  1  0 = word arrives MSB first (left-shift source), 1 = LSB first (right-shift source).
REQ-006 The block SHALL expose CLEAR  input  1  synchronous abort of the word in progress.
REQ-007 The block SHALL expose OUT  output  4  last completed parallel word.
REQ-008 The block SHALL expose OUT_VALID  output  1  single-cycle pulse marking a new OUT.
REQ-009 The block SHALL expose BUSY  output  1  high while a word is partially collected.
REQ-010 The block SHALL expose COUNT  output  3  data bits accepted in the current word (0-4).

Function
REQ-011 FSM states SHALL be IDLE, COLLECT and, with parity compiled in, PARITY.
REQ-012 In IDLE, BIT_VALID=1 SHALL accept bit 0, latch DIR into an internal direction register, set COUNT=1 and enter COLLECT.
REQ-013 DIR SHALL be ignored after the first bit until the word completes or aborts.
REQ-014 MSB-first: each accepted bit SHALL enter at bit 0 with the assembly register shifting left; LSB-first: each bit SHALL enter at bit 3 with the register shifting right.
REQ-015 In COLLECT, each BIT_VALID=1 edge SHALL increment COUNT; BIT_VALID=0 SHALL hold all state (gaps of any length allowed).
REQ-016 On acceptance of the 4th data bit without parity, OUT SHALL update with the assembled word and OUT_VALID SHALL be high in the following cycle only; FSM returns to IDLE, COUNT=0.
REQ-017 Latency SHALL be exactly one cycle from the 4th accepted bit (or parity bit) to OUT/OUT_VALID.
REQ-018 Back-to-back: a bit presented in the cycle OUT_VALID is high SHALL be accepted as bit 0 of the next word.
REQ-019 OUT SHALL hold its value between completions; only a completed word updates OUT.
REQ-020 CLEAR=1 SHALL return the FSM to IDLE and COUNT to 0, discard the partial word, leave OUT unchanged, and take priority over a simultaneous BIT_VALID.
REQ-021 BUSY SHALL equal (state != IDLE).

Reset
REQ-022 RESET=0 SHALL immediately force IDLE, OUT=4'b0000, OUT_VALID=0, BUSY=0, COUNT=0, direction register=0 and, if present, PARITY_ERR=0, regardless of clock.
REQ-023 Reset asserted mid-word SHALL discard the partial word; the first BIT_VALID after release starts a fresh word.

Configuration
REQ-024 Macro DESER_PARITY_EN SHALL, when defined, add PARITY_ERR (output, 1) and a PARITY state: after the 4th data bit the FSM enters PARITY, the next accepted bit is an even-parity bit, OUT updates, OUT_VALID pulses, and PARITY_ERR = XOR of the 4 data bits and parity bit, valid in the OUT_VALID cycle only.
REQ-025 When DESER_PARITY_EN is undefined, there SHALL be no PARITY state and no PARITY_ERR port, and words complete after 4 bits.

Structure
REQ-026 State encodings (IDLE, COLLECT, PARITY) and the word width constant 4 SHALL live in the shared ALU definitions package/include used by the shift register.
REQ-027 The block SHALL be a single module with no sub-modules; the assembly register SHALL be local.

Verification
REQ-028 MSB-first: DIR=0, bits 1,0,1,1 on consecutive cycles -> OUT=4'b1011, OUT_VALID one cycle after the 4th bit, COUNT back to 0.
REQ-029 LSB-first: DIR=1, bits 1,0,1,1 -> OUT=4'b1101; DIR toggled after the first bit has no effect.
REQ-030 Gaps and back-to-back: DIR=0, bits 0,1 (gap 3 cycles) 1,0 -> OUT=4'b0110; next word 1,1,1,1 starting in the OUT_VALID cycle -> OUT=4'b1111.
REQ-031 Abort: two bits then CLEAR=1 with BIT_VALID=1 -> COUNT=0, BUSY=0, OUT holds the previous word, no OUT_VALID.
REQ-032 Async reset: RESET=0 between clock edges after 3 bits -> all outputs zero immediately; after release, bits 0,0,0,1 with DIR=0 -> OUT=4'b0001.
REQ-033 With DESER_PARITY_EN: data 1,0,1,1 then parity 1 -> OUT=4'b1011, PARITY_ERR=0; parity 0 -> PARITY_ERR=1.
